// File: rtl/march_bist_ctrl_if.sv
// Single-port synchronous RAM bus between the BIST controller (master) and the RAM (slave).
interface march_bist_ctrl_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_we,
        output mem_re,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        input  mem_re,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/march_bist_ctrl.sv
// March C- / MATS+ memory BIST controller: sequences RAM ops, compares reads one cycle
// later, records the first failing address/element and a saturating mismatch count.
module march_bist_ctrl #(
    parameter int unsigned       ADDR_W       = 4,
    parameter int unsigned       DATA_W       = 8,
    parameter logic [DATA_W-1:0] BACKGROUND   = '0,
    parameter int unsigned       ERR_W        = 8,
    parameter bit                STOP_ON_FAIL = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic                     mode_i,
    march_bist_ctrl_if.master        mem,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     fail_o,
    output logic [ADDR_W-1:0]        fail_addr_o,
    output logic [2:0]               fail_elem_o,
    output logic [ERR_W-1:0]         err_cnt_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [2:0]        elem_q, elem_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cmp_valid_q, cmp_valid_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic [2:0]        cmp_elem_q, cmp_elem_d;
    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]        fail_elem_q, fail_elem_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    // Current element shape and the op at op_q; val is the logical data value (0/1).
    logic two_ops, down, rd, val, last_elem, next_down;

    always_comb begin
        two_ops   = 1'b1;
        down      = 1'b0;
        rd        = 1'b0;
        val       = 1'b0;
        last_elem = 1'b0;
        next_down = 1'b0;
        if (!mode_q) begin
            case (elem_q)
                3'd0:    two_ops = 1'b0;
                3'd1:    begin rd = ~op_q; val = op_q; end
                3'd2:    begin rd = ~op_q; val = ~op_q; next_down = 1'b1; end
                3'd3:    begin down = 1'b1; rd = ~op_q; val = op_q; next_down = 1'b1; end
                3'd4:    begin down = 1'b1; rd = ~op_q; val = ~op_q; end
                3'd5:    begin two_ops = 1'b0; rd = 1'b1; last_elem = 1'b1; end
                default: two_ops = 1'b0;
            endcase
        end else begin
            case (elem_q)
                3'd0:    two_ops = 1'b0;
                3'd1:    begin rd = ~op_q; val = op_q; next_down = 1'b1; end
                3'd2:    begin down = 1'b1; rd = ~op_q; val = ~op_q; last_elem = 1'b1; end
                default: two_ops = 1'b0;
            endcase
        end
    end

    logic              mismatch;
    logic              at_end;
    logic [DATA_W-1:0] word;
    logic              mem_we, mem_re;
    logic [DATA_W-1:0] mem_wdata;

    assign mismatch = cmp_valid_q && (mem.mem_rdata != exp_q);
    assign word     = val ? ~BACKGROUND : BACKGROUND;
    assign at_end   = down ? (addr_q == '0) : (addr_q == '1);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        elem_d      = elem_q;
        op_d        = op_q;
        addr_d      = addr_q;
        cmp_valid_d = 1'b0;
        exp_d       = exp_q;
        cmp_addr_d  = cmp_addr_q;
        cmp_elem_d  = cmp_elem_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        err_cnt_d   = err_cnt_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_wdata   = '0;

        // Compare of the read issued last cycle; also live in DRAIN for the final read.
        if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (!fail_q) begin
                fail_d      = 1'b1;
                fail_addr_d = cmp_addr_q;
                fail_elem_d = cmp_elem_q;
            end
        end

        case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d     = StRun;
                    mode_d      = mode_i;
                    elem_d      = '0;
                    op_d        = 1'b0;
                    addr_d      = '0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = '0;
                    err_cnt_d   = '0;
                end
            end
            StRun: begin
                if (rd) begin
                    mem_re      = 1'b1;
                    cmp_valid_d = 1'b1;
                    exp_d       = word;
                    cmp_addr_d  = addr_q;
                    cmp_elem_d  = elem_q;
                end else begin
                    mem_we    = 1'b1;
                    mem_wdata = word;
                end
                if (two_ops && !op_q) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (at_end) begin
                        elem_d = elem_q + 3'd1;
                        addr_d = next_down ? '1 : '0;
                        if (last_elem) state_d = StDrain;
                    end else begin
                        addr_d = down ? addr_q - 1'b1 : addr_q + 1'b1;
                    end
                end
                if (STOP_ON_FAIL && mismatch) state_d = StDrain;
            end
            StDrain: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            elem_q      <= '0;
            op_q        <= 1'b0;
            addr_q      <= '0;
            cmp_valid_q <= 1'b0;
            exp_q       <= '0;
            cmp_addr_q  <= '0;
            cmp_elem_q  <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            elem_q      <= elem_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            cmp_valid_q <= cmp_valid_d;
            exp_q       <= exp_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_elem_q  <= cmp_elem_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign mem.mem_addr  = addr_q;
    assign mem.mem_we    = mem_we;
    assign mem.mem_re    = mem_re;
    assign mem.mem_wdata = mem_wdata;

    assign busy_o      = (state_q == StRun) || (state_q == StDrain);
    assign done_o      = (state_q == StDone);
    assign fail_o      = fail_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_elem_o = fail_elem_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Three controllers (default, stop-on-fail, 2-bit error counter) against faulty RAM models;
// a March reference model fills op/status queues that per-DUT monitors pop and compare.
module tb_march_bist_ctrl;

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wd;
    } op_t;

    typedef struct packed {
        logic        fail;
        logic [3:0]  fa;
        logic [2:0]  fe;
        logic [7:0]  err;
        logic [31:0] when;
    } st_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic mode = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    op_t        exp_ops [3][$];
    st_t        exp_st  [3][$];
    logic       done_prev [3];
    logic [7:0] ram [3][16];
    logic [7:0] sa0 [3][16];
    logic [7:0] sa1 [3][16];

    logic       busy0, done0, fail0, busy1, done1, fail1, busy2, done2, fail2;
    logic [3:0] fa0, fa1, fa2;
    logic [2:0] fe0, fe1, fe2;
    logic [7:0] err0, err1;
    logic [1:0] err2;

    march_bist_ctrl_if #(.ADDR_W(4), .DATA_W(8)) mif0 ();
    march_bist_ctrl_if #(.ADDR_W(4), .DATA_W(8)) mif1 ();
    march_bist_ctrl_if #(.ADDR_W(4), .DATA_W(8)) mif2 ();

    march_bist_ctrl #(.ADDR_W(4), .DATA_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode), .mem(mif0),
        .busy_o(busy0), .done_o(done0), .fail_o(fail0), .fail_addr_o(fa0),
        .fail_elem_o(fe0), .err_cnt_o(err0)
    );
    march_bist_ctrl #(.ADDR_W(4), .DATA_W(8), .STOP_ON_FAIL(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode), .mem(mif1),
        .busy_o(busy1), .done_o(done1), .fail_o(fail1), .fail_addr_o(fa1),
        .fail_elem_o(fe1), .err_cnt_o(err1)
    );
    march_bist_ctrl #(.ADDR_W(4), .DATA_W(8), .ERR_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode), .mem(mif2),
        .busy_o(busy2), .done_o(done2), .fail_o(fail2), .fail_addr_o(fa2),
        .fail_elem_o(fe2), .err_cnt_o(err2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] flt(input int d, input int a, input logic [7:0] v);
        return (v | sa1[d][a]) & ~sa0[d][a];
    endfunction

    always @(posedge clk) begin
        if (mif0.mem_we) ram[0][mif0.mem_addr] <= flt(0, int'(mif0.mem_addr), mif0.mem_wdata);
        if (mif0.mem_re) mif0.mem_rdata <= flt(0, int'(mif0.mem_addr), ram[0][mif0.mem_addr]);
        if (mif1.mem_we) ram[1][mif1.mem_addr] <= flt(1, int'(mif1.mem_addr), mif1.mem_wdata);
        if (mif1.mem_re) mif1.mem_rdata <= flt(1, int'(mif1.mem_addr), ram[1][mif1.mem_addr]);
        if (mif2.mem_we) ram[2][mif2.mem_addr] <= flt(2, int'(mif2.mem_addr), mif2.mem_wdata);
        if (mif2.mem_re) mif2.mem_rdata <= flt(2, int'(mif2.mem_addr), ram[2][mif2.mem_addr]);
    end

    function automatic void chk(input string nm, input int d, input logic [63:0] act,
                                input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", nm, d, act, exp, $time);
    endfunction

    // Op codes: 0=w0 1=w1 2=r0 3=r1, -1 = no second op.
    function automatic int op_code(input bit md, input int e, input int k);
        int c [6][2];
        if (!md) c = '{'{0, -1}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, -1}};
        else     c = '{'{0, -1}, '{2, 1}, '{3, 0}, '{-1, -1}, '{-1, -1}, '{-1, -1}};
        return c[e][k];
    endfunction

    function automatic bit elem_down(input bit md, input int e);
        return md ? (e == 2) : (e == 3 || e == 4);
    endfunction

    task automatic ref_run(input int d, input bit md, output int issued, output st_t st);
        logic [7:0] m [16];
        int  errs, errmax, nel;
        bit  prev_mm, fin, stop;
        errs = 0; prev_mm = 0; fin = 0; issued = 0; st = '0;
        stop   = (d == 1);
        errmax = (d == 2) ? 3 : 255;
        nel    = md ? 3 : 6;
        for (int e = 0; e < nel && !fin; e++) begin
            for (int i = 0; i < 16 && !fin; i++) begin
                for (int k = 0; k < 2 && !fin; k++) begin
                    int c, a;
                    logic [7:0] w;
                    op_t o;
                    bit mm;
                    c = op_code(md, e, k);
                    a = elem_down(md, e) ? 15 - i : i;
                    if (c >= 0) begin
                        w = (c % 2 == 1) ? 8'hFF : 8'h00;
                        o.we = (c < 2);
                        o.addr = a[3:0];
                        o.wd = o.we ? w : 8'h00;
                        exp_ops[d].push_back(o);
                        issued++;
                        mm = 0;
                        if (c < 2) m[a] = flt(d, a, w);
                        else if (flt(d, a, m[a]) != w) begin
                            mm = 1;
                            errs++;
                            if (!st.fail) begin
                                st.fail = 1'b1;
                                st.fa = a[3:0];
                                st.fe = e[2:0];
                            end
                        end
                        if (stop && prev_mm) fin = 1;
                        prev_mm = mm;
                    end
                end
            end
        end
        st.err = (errs > errmax) ? errmax[7:0] : errs[7:0];
    endtask

    function automatic void mon(input int d, input logic we, input logic re,
                                input logic [3:0] a, input logic [7:0] wd, input logic dn,
                                input logic fl, input logic [3:0] fa, input logic [2:0] fe,
                                input logic [7:0] err);
        op_t o;
        st_t s;
        if (we || re) begin
            chk("op_pending", d, exp_ops[d].size() > 0, 1);
            if (exp_ops[d].size() > 0) begin
                o = exp_ops[d].pop_front();
                chk("op", d, {we, re, a, (we ? wd : 8'h00)}, {o.we, ~o.we, o.addr, o.wd});
            end
        end
        if (dn && !done_prev[d]) begin
            chk("done_pending", d, exp_st[d].size() > 0, 1);
            if (exp_st[d].size() > 0) begin
                s = exp_st[d].pop_front();
                chk("status", d, {fl, fa, fe, err}, {s.fail, s.fa, s.fe, s.err});
                chk("done_cycle", d, cyc, s.when);
            end
        end
        done_prev[d] = dn;
    endfunction

    always @(negedge clk) mon(0, mif0.mem_we, mif0.mem_re, mif0.mem_addr, mif0.mem_wdata,
                              done0, fail0, fa0, fe0, err0);
    always @(negedge clk) mon(1, mif1.mem_we, mif1.mem_re, mif1.mem_addr, mif1.mem_wdata,
                              done1, fail1, fa1, fe1, err1);
    always @(negedge clk) mon(2, mif2.mem_we, mif2.mem_re, mif2.mem_addr, mif2.mem_wdata,
                              done2, fail2, fa2, fe2, {6'd0, err2});

    task automatic clear_faults();
        for (int d = 0; d < 3; d++)
            for (int a = 0; a < 16; a++) begin
                sa0[d][a] = 8'h00;
                sa1[d][a] = 8'h00;
            end
    endtask

    task automatic clear_queues();
        for (int d = 0; d < 3; d++) begin
            exp_ops[d].delete();
            exp_st[d].delete();
        end
    endtask

    task automatic run_test(input bit md, input bit mid);
        int  iss [3];
        st_t st [3];
        int  sc;
        bit  all_done;
        for (int d = 0; d < 3; d++) ref_run(d, md, iss[d], st[d]);
        @(negedge clk);
        #1 start = 1'b1;
        mode = md;
        sc = cyc;
        for (int d = 0; d < 3; d++) begin
            st[d].when = sc + iss[d] + 2;
            exp_st[d].push_back(st[d]);
        end
        @(negedge clk);
        #1 start = 1'b0;
        if (mid) begin
            repeat (39) @(negedge clk);
            #1 start = 1'b1;
            mode = ~md;
            @(negedge clk);
            #1 start = 1'b0;
            repeat (9) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("rst_mid_dut0", 0, {busy0, done0, fail0, fa0, fe0, err0, mif0.mem_we,
                                    mif0.mem_re, mif0.mem_addr, mif0.mem_wdata}, 0);
            chk("rst_mid_dut1", 1, {busy1, mif1.mem_we, mif1.mem_re}, 0);
            chk("rst_mid_dut2", 2, {busy2, mif2.mem_we, mif2.mem_re}, 0);
            clear_queues();
            repeat (3) @(negedge clk);
            chk("rst_no_done", 0, {done0, done1, done2, busy0}, 0);
            #2 rst_n = 1'b1;
        end else begin
            all_done = 0;
            for (int i = 0; i < 400 && !all_done; i++) begin
                @(negedge clk);
                all_done = done0 && done1 && done2;
            end
            #1 chk("done_timeout", 0, all_done, 1);
        end
        for (int d = 0; d < 3; d++) begin
            chk("ops_left", d, exp_ops[d].size(), 0);
            chk("status_left", d, exp_st[d].size(), 0);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) done_prev[d] = 1'b0;
        clear_faults();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_dut0", 0, {busy0, done0, fail0, fa0, fe0, err0, mif0.mem_we, mif0.mem_re,
                              mif0.mem_addr, mif0.mem_wdata}, 0);
        chk("reset_dut2", 2, {busy2, done2, fail2, err2, mif2.mem_we, mif2.mem_re}, 0);
        #2 rst_n = 1'b1;

        run_test(1'b0, 1'b0);
        chk("clean_c_fail", 0, {fail0, err0}, 0);
        run_test(1'b1, 1'b0);
        chk("clean_mats_fail", 0, {fail0, err0}, 0);

        sa1[0][5] = 8'h01;
        sa0[1][5] = 8'h08;
        for (int a = 0; a < 16; a++) sa0[2][a] = 8'hFF;
        run_test(1'b0, 1'b0);
        chk("sa1_a5b0", 0, {fail0, fa0, fe0, err0}, {1'b1, 4'd5, 3'd1, 8'd3});
        chk("stop_a5b3", 1, {fail1, fa1, fe1, err1, done1}, {1'b1, 4'd5, 3'd2, 8'd1, 1'b1});
        chk("sat_all0", 2, {fail2, fa2, fe2, err2}, {1'b1, 4'd0, 3'd2, 2'd3});

        clear_faults();
        run_test(1'b0, 1'b1);
        run_test(1'b0, 1'b0);

        for (int r = 0; r < 5; r++) begin
            clear_faults();
            for (int d = 0; d < 3; d++) begin
                if ($urandom_range(0, 3) != 0) begin
                    int a, b;
                    a = $urandom_range(0, 15);
                    b = $urandom_range(0, 7);
                    if ($urandom_range(0, 1) == 1) sa1[d][a][b] = 1'b1;
                    else sa0[d][a][b] = 1'b1;
                end
            end
            run_test(1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/march_bist_ctrl.md
Name: march_bist_ctrl

Overview:
- Parametrised memory built-in self-test controller.
- Owns its address counter and drives a single-port synchronous RAM directly.
- Runs a selectable March algorithm: March C- or MATS+.
- Compares read data against expected values, captures the first failing location and counts mismatches.
- Sits between the test-mode start/status logic and the RAM under test.

Parameters:
- ADDR_W, 4: address width; memory depth N = 2^ADDR_W.
- DATA_W, 8: memory word width.
- BACKGROUND, {DATA_W{1'b0}}: word written/expected for logical 0. Logical 1 = ~BACKGROUND.
- ERR_W, 8: width of the saturating error counter.
- STOP_ON_FAIL, 0: 1 = abort the test on the first mismatch.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a test when not busy
- mode  in  1  0 = March C-, 1 = MATS+; sampled with start
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_re  out  1  RAM read enable; mem_rdata valid the following cycle
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data
- busy  out  1  test in progress
- done  out  1  test finished; held until next start
- fail  out  1  at least one mismatch since last start
- fail_addr  out  ADDR_W  address of first mismatch
- fail_elem  out  3  March element index of first mismatch
- err_cnt  out  ERR_W  mismatch count, saturating at all-ones

Behaviour:
- Reset (rst_n low, async): all outputs 0. FSM to IDLE. Counters cleared.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start:
  - latch mode; clear fail, fail_addr, fail_elem, err_cnt and done; busy=1.
  - go to RUN; the first memory op is issued the cycle after start.
- start while busy is ignored.
- March C- (mode 0), elements 0..5:
  - 0: up w0
  - 1: up (r0, w1)
  - 2: up (r1, w0)
  - 3: down (r0, w1)
  - 4: down (r1, w0)
  - 5: up r0
- MATS+ (mode 1), elements 0..2:
  - 0: up w0
  - 1: up (r0, w1)
  - 2: down (r1, w0)
- Element execution:
  - one op per cycle; all ops of an element are performed at one address before the address steps.
  - up = 0..N-1; down = N-1..0.
  - address wraps to the element's start value when the element ends; element index then increments.
- Op outputs:
  - write op: mem_we=1, mem_re=0, mem_wdata = BACKGROUND or ~BACKGROUND.
  - read op: mem_re=1, mem_we=0.
  - mem_we and mem_re are never both 1. Both are 0 outside RUN.
- Compare pipeline:
  - on each read, register the expected word, mem_addr and element index.
  - next cycle, compare mem_rdata against the expected word.
  - on mismatch: err_cnt += 1 (saturating). If fail was 0: set fail=1, capture fail_addr and fail_elem.
- Run length and end of test:
  - RUN lasts exactly ops_total*N cycles: March C- 10N, MATS+ 5N.
  - after the last op, go to DRAIN for one cycle so the final read is compared.
  - then DONE: busy=0, done=1.
  - done rises 10N+2 cycles after the start cycle (March C-), 5N+2 (MATS+).
- STOP_ON_FAIL=1: a mismatch detected in RUN moves the FSM to DRAIN the next cycle.
  - no further ops are issued after the one in flight.
  - the in-flight read is still compared.
  - done then asserts; err_cnt counts every compared mismatch.
- Simultaneous mismatch and final-op cycle: the compare in DRAIN is still counted and captured.
- Reset mid-test: the async clear aborts immediately; mem_we/mem_re drop with rst_n; no done pulse.
- Status outputs hold their values in DONE until the next accepted start.

Test Plan:
- ADDR_W=4, DATA_W=8, fault-free RAM model, mode=0, start pulse:
  - 160 op cycles issued with addresses in the listed order.
  - done=1 at start+162; fail=0; err_cnt=0.
- Same setup, mode=1 -> 80 op cycles; done at start+82; fail=0.
- mode=0, bit 0 of address 5 stuck-at-1 -> fail=1, fail_addr=5, fail_elem=1, err_cnt=3 (elements 1, 3, 5).
- STOP_ON_FAIL=1, address 5 bit 3 stuck-at-0, mode=0:
  - fail_elem=2, fail_addr=5.
  - no ops issued after the mismatch detect cycle.
  - done=1, err_cnt=1.
- ERR_W=2, all cells stuck-at-0 (reads return 0x00), mode=0 -> err_cnt saturates at 3; fail_addr=0, fail_elem=2.
- Mid-test handling:
  - start pulsed at op cycle 40 -> ignored, sequence unchanged.
  - rst_n low at op cycle 50 -> all outputs 0 immediately.
  - new start after release -> full clean run with done at start+162.
